// File: rtl/text_glyph_sequencer.sv
// Text-mode pixel sequencer: screen coordinate -> display RAM address -> glyph ROM
// address -> registered colour, with matched sync/blank delay and a blinking underline cursor.
module text_glyph_sequencer #(
  parameter int H_COLS        = 80,
  parameter int V_ROWS        = 60,
  parameter int RAM_ADDR_BITS = 13,
  parameter int CHAR_AMNT     = 7,
  parameter int PIXEL_BITS    = 3,
  parameter int ROM_WIDTH     = 8,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pixel_en,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     video_on_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  input  logic [CHAR_AMNT-1:0]     ram_data,
  output logic [CHAR_AMNT-1:0]     glyph_addr,
  output logic [PIXEL_BITS-1:0]    v_pixel,
  output logic [PIXEL_BITS-1:0]    h_pixel,
  input  logic [ROM_WIDTH-1:0]     rom_color,
  input  logic                     cursor_en,
  input  logic [RAM_ADDR_BITS-1:0] cursor_addr,
  output logic [ROM_WIDTH-1:0]     color_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     video_on_out
);

  localparam int FW    = $clog2(BLINK_FRAMES + 1);
  localparam int CELLS = H_COLS * V_ROWS;

  typedef struct packed {
    logic [PIXEL_BITS-1:0] h;
    logic [PIXEL_BITS-1:0] v;
    logic                  vid;
    logic                  hs;
    logic                  vs;
    logic                  hit;
    logic                  inr;
  } stage_t;

  // Syncs idle high so a flushed pipeline never emits a spurious sync pulse.
  localparam stage_t STAGE_RST = '{h: '0, v: '0, vid: 1'b0, hs: 1'b1, vs: 1'b1,
                                   hit: 1'b0, inr: 1'b0};

  logic [RAM_ADDR_BITS-1:0] row_ext_s, col_ext_s, addr_s;
  logic [RAM_ADDR_BITS-1:0] ram_addr_q;
  stage_t                   s0_d, s0_q, s1_q;
  logic [ROM_WIDTH-1:0]     pix_color_s, color_q;
  logic                     hs_out_q, vs_out_q, vid_out_q;
  logic                     vs_prev_q, vs_fall_s;
  logic [FW-1:0]            frame_d, frame_q;
  logic                     blink_d, blink_q;

  assign row_ext_s = RAM_ADDR_BITS'(vcount[9:PIXEL_BITS]);
  assign col_ext_s = RAM_ADDR_BITS'(hcount[9:PIXEL_BITS]);

  generate
    if (H_COLS == 80) begin : g_mul80
      assign addr_s = (row_ext_s << 4'd6) + (row_ext_s << 4'd4) + col_ext_s;
    end else begin : g_mul
      assign addr_s = row_ext_s * RAM_ADDR_BITS'(H_COLS) + col_ext_s;
    end
  endgenerate

  // Stage-0 capture of the coordinate's low bits, flags and cursor compare.
  always_comb begin
    s0_d     = STAGE_RST;
    s0_d.h   = hcount[PIXEL_BITS-1:0];
    s0_d.v   = vcount[PIXEL_BITS-1:0];
    s0_d.vid = video_on_in;
    s0_d.hs  = hsync_in;
    s0_d.vs  = vsync_in;
    s0_d.hit = (addr_s == cursor_addr);
    s0_d.inr = (addr_s < RAM_ADDR_BITS'(CELLS));
  end

  // Pixel colour selection: blanking, out-of-range cells, then cursor underline.
  always_comb begin
    if (!s1_q.vid || !s1_q.inr) begin
      pix_color_s = '0;
    end else if (s1_q.hit && cursor_en && blink_q && (s1_q.v == {PIXEL_BITS{1'b1}})) begin
      pix_color_s = ~rom_color;
    end else begin
      pix_color_s = rom_color;
    end
  end

  assign vs_fall_s = vs_prev_q & ~vsync_in;

  // Blink frame counter: count vsync falling edges, toggle phase on wrap.
  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (vs_fall_s) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // Pipeline, output and blink registers; everything advances only on the pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_q <= '0;
      s0_q       <= STAGE_RST;
      s1_q       <= STAGE_RST;
      color_q    <= '0;
      hs_out_q   <= 1'b1;
      vs_out_q   <= 1'b1;
      vid_out_q  <= 1'b0;
      vs_prev_q  <= 1'b1;
      frame_q    <= '0;
      blink_q    <= 1'b0;
    end else if (pixel_en) begin
      ram_addr_q <= addr_s;
      s0_q       <= s0_d;
      s1_q       <= s0_q;
      color_q    <= pix_color_s;
      hs_out_q   <= s1_q.hs;
      vs_out_q   <= s1_q.vs;
      vid_out_q  <= s1_q.vid;
      vs_prev_q  <= vsync_in;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
    end
  end

  // Glyph code is blanked outside the active area so the ROM address is quiet there.
  assign glyph_addr   = s1_q.vid ? ram_data : '0;
  assign v_pixel      = s1_q.v;
  assign h_pixel      = s1_q.h;
  assign ram_addr     = ram_addr_q;
  assign color_out    = color_q;
  assign hsync_out    = hs_out_q;
  assign vsync_out    = vs_out_q;
  assign video_on_out = vid_out_q;

endmodule
